// File: rtl/keypad_bcd_scanner.sv
// Keypad scanner for a 10-key decimal pad.
// Key lines are synchronized and debounced, and each qualified press is encoded to BCD.
// Digits are queued in a show-ahead FIFO. Two sticky flags report dropped digits
// and simultaneous key presses.
module keypad_bcd_scanner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key,
    input  logic       clr,
    output logic [3:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [4:0] fifo_count,
    output logic       overflow,
    output logic       multi_err
);

    localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] DEPTH_C  = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        HOLD     = 2'd3
    } state_t;

    // One-hot key vector to its decimal index (only called with one-hot input).
    function automatic logic [3:0] onehot_to_bcd(input logic [9:0] v);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                code = 4'(i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    // True when two or more key lines are active at once.
    function automatic logic is_multi(input logic [9:0] v);
        return (v & (v - 10'd1)) != 10'd0;
    endfunction

    logic [9:0]    sync1_r;
    logic [9:0]    ks_r;
    state_t        state_r;
    state_t        state_next_s;
    logic [9:0]    cap_r;
    logic [9:0]    cap_next_s;
    logic [7:0]    cnt_r;
    logic [7:0]    cnt_next_s;
    logic          push_s;
    logic          set_multi_s;

    logic [3:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_next_s;
    logic [PW-1:0] wr_next_s;
    logic [4:0]    count_r;
    logic [4:0]    count_next_s;
    logic          pop_s;
    logic          push_ok_s;
    logic          drop_s;
    logic [3:0]    push_data_s;
    logic [3:0]    head_s;
    logic [3:0]    dout_r;
    logic          dout_valid_r;
    logic          overflow_r;
    logic          multi_err_r;

    // Two-stage synchronizer for the asynchronous key lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 10'd0;
            ks_r    <= 10'd0;
        end else begin
            sync1_r <= key;
            ks_r    <= sync1_r;
        end
    end

    // Scanner state, captured key and debounce counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cap_r   <= 10'd0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_next_s;
            cap_r   <= cap_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic: qualify a stable single key, emit once, wait for release.
    always_comb begin
        state_next_s = state_r;
        cap_next_s   = cap_r;
        cnt_next_s   = cnt_r;
        push_s       = 1'b0;
        set_multi_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (ks_r == 10'd0) begin
                    state_next_s = IDLE;
                end else if (is_multi(ks_r)) begin
                    set_multi_s = 1'b1;
                end else begin
                    state_next_s = DEBOUNCE;
                    cap_next_s   = ks_r;
                    cnt_next_s   = 8'd1;
                end
            end
            DEBOUNCE: begin
                if (ks_r != cap_r) begin
                    state_next_s = IDLE;
                    set_multi_s  = is_multi(ks_r);
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = EMIT;
                end else begin
                    cnt_next_s = cnt_r + 8'd1;
                end
            end
            EMIT: begin
                push_s       = 1'b1;
                state_next_s = HOLD;
            end
            HOLD: begin
                if (ks_r == 10'd0) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FIFO handshake: a pop may free the slot a same-edge push needs.
    always_comb begin
        pop_s       = dout_valid_r & dout_ready;
        push_ok_s   = push_s & ((count_r < DEPTH_C) | pop_s);
        drop_s      = push_s & ~push_ok_s;
        push_data_s = onehot_to_bcd(cap_r);
        if (pop_s) begin
            rd_next_s = rd_ptr_r + PW'(1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        if (push_ok_s) begin
            wr_next_s = wr_ptr_r + PW'(1);
        end else begin
            wr_next_s = wr_ptr_r;
        end
    end

    // Occupancy after this edge and the entry that will sit at the head.
    always_comb begin
        count_next_s = count_r;
        if (push_ok_s && !pop_s) begin
            count_next_s = count_r + 5'd1;
        end else if (!push_ok_s && pop_s) begin
            count_next_s = count_r - 5'd1;
        end else begin
            count_next_s = count_r;
        end
        // A digit written this edge into the new head slot bypasses the memory.
        if (push_ok_s && (rd_next_s == wr_ptr_r)) begin
            head_s = push_data_s;
        end else begin
            head_s = mem_r[rd_next_s];
        end
    end

    // FIFO storage, pointers, registered head, and sticky flags; clr flushes all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 4'd0;
            end
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= 5'd0;
            dout_r       <= 4'd0;
            dout_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            multi_err_r  <= 1'b0;
        end else if (clr) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= 5'd0;
            dout_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            multi_err_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
            end
            rd_ptr_r     <= rd_next_s;
            wr_ptr_r     <= wr_next_s;
            count_r      <= count_next_s;
            dout_valid_r <= (count_next_s != 5'd0);
            if (count_next_s != 5'd0) begin
                dout_r <= head_s;
            end
            overflow_r  <= overflow_r | drop_s;
            multi_err_r <= multi_err_r | set_multi_s;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;
    assign multi_err  = multi_err_r;

endmodule

// File: doc/keypad_bcd_scanner.md
KEYPAD_BCD_SCANNER -- requirements
Module: keypad_bcd_scanner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive identical synchronized samples that qualify a key press (legal range 2..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the digit buffer depth (power of 2, legal range 2..16).
REQ-003 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port key  input  10  asynchronous key lines; key[i] high means decimal key i is pressed.
REQ-006 SHALL have port clr  input  1  synchronous flush of the buffer and sticky flags.
REQ-007 SHALL have port dout  output  4  BCD digit at the buffer head.
REQ-008 SHALL have port dout_valid  output  1  buffer non-empty.
REQ-009 SHALL have port dout_ready  input  1  consumer accepts dout.
REQ-010 SHALL have port fifo_count  output  5  number of buffered digits.
REQ-011 SHALL have port overflow  output  1  sticky flag: a qualified digit was dropped.
REQ-012 SHALL have port multi_err  output  1  sticky flag: more than one key was seen active.

Function
REQ-013 SHALL pass key through a 2-flop synchronizer; the FSM observes only ks (the second-stage value).
REQ-014 SHALL implement FSM states IDLE, DEBOUNCE, EMIT and HOLD.
REQ-015 IDLE: ks==0 -> stay; ks one-hot -> DEBOUNCE, capture ks into cap, set cnt=1; ks with two or more bits -> set multi_err, stay in IDLE.
REQ-016 DEBOUNCE: ks!=cap -> IDLE (no emit, multi_err set if ks has two or more bits); ks==cap and cnt==DEBOUNCE_CYCLES-1 -> EMIT; otherwise cnt+1.
REQ-017 EMIT (exactly one cycle): push the BCD of cap; -> HOLD.
REQ-018 HOLD: stay until ks==0, then -> IDLE; a change to another key while held SHALL NOT emit.
REQ-019 BCD encoding SHALL be key index i -> 4-bit binary i (key[8] -> 4'b1000, key[9] -> 4'b1001); codes 1010..1111 SHALL never be produced.
REQ-020 Latency: with key held stable from before clock edge 1, dout_valid SHALL rise after edge 3+DEBOUNCE_CYCLES (edge 7 for the default).
REQ-021 The buffer SHALL be a show-ahead FIFO: dout shows the head entry whenever dout_valid=1.
REQ-022 A pop SHALL occur on a clock edge where dout_valid && dout_ready.
REQ-023 A push SHALL be accepted if fifo_count<FIFO_DEPTH or a pop occurs on the same edge.
REQ-024 A push that is not accepted SHALL drop the digit and set overflow; buffer contents SHALL be unchanged.
REQ-025 When push and pop occur on the same edge, fifo_count SHALL be unchanged.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 dout_ready while dout_valid=0 SHALL have no effect.
REQ-028 clr=1 SHALL empty the FIFO and clear overflow and multi_err on that edge; a push or pop on the same edge SHALL be discarded, and the FSM SHALL be unaffected.
REQ-029 dout SHALL hold its last value when the FIFO is empty; consumers SHALL ignore dout while dout_valid=0.

Reset
REQ-030 rst_n=0 SHALL immediately force: synchronizer=0, FSM=IDLE, cnt=0, cap=0, FIFO empty, fifo_count=0, dout=0, dout_valid=0, overflow=0, multi_err=0.
REQ-031 Reset asserted mid-DEBOUNCE or mid-EMIT SHALL abort the press with no digit buffered; after release a key still held SHALL re-qualify from IDLE.

Verification
REQ-032 Bench SHALL apply key=10'b0000001000 held 10 cycles, dout_ready=1 -> dout=4'd3, dout_valid high exactly 1 cycle after edge 7, no second emit while held.
REQ-033 Bench SHALL apply key[9] then key[8] presses with dout_ready=0 -> fifo_count=2, dout=4'b1001, then 4'b1000 after one pop.
REQ-034 Bench SHALL apply key[2] pulsed for 2 cycles (bounce), then 0 -> no emit, fifo_count stays 0.
REQ-035 Bench SHALL apply key=10'b0000010001 -> multi_err=1, no emit; then clr=1 for one cycle -> multi_err=0.
REQ-036 Bench SHALL apply 5 distinct presses with dout_ready=0 and FIFO_DEPTH=4 -> fifo_count=4, overflow=1, first four digits read back in order.
REQ-037 Bench SHALL apply a press with FIFO full and dout_ready=1 on the EMIT edge -> push accepted, fifo_count stays 4, overflow=0.
